// File: rtl/wci_pkg.sv
// Shared encodings for the WCI initiator: OCP command/response codes,
// response status codes and the initiator state enum.
package wci_pkg;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1,
    MCMD_RD   = 3'd2
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'd0,
    SRESP_DVA  = 2'd1,
    SRESP_FAIL = 2'd2,
    SRESP_ERR  = 2'd3
  } sresp_e;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_FAIL    = 2'd1;
  localparam logic [1:0] RSP_ERR     = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Only called with a non-NULL response.
  function automatic logic [1:0] resp_to_code(input logic [1:0] sresp);
    case (sresp)
      SRESP_DVA:  resp_to_code = RSP_OK;
      SRESP_FAIL: resp_to_code = RSP_FAIL;
      default:    resp_to_code = RSP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/wci_init_timer.sv
// Clearable, saturating up-counter; o_tc is high while the count is all ones.
module wci_init_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = &r_cnt;

endmodule

// File: rtl/wci_initiator.sv
// WCI master: one control-plane request at a time, issued as an OCP command.
// Optional response timeout and abort pulse under `WCI_INITIATOR_TIMEOUT_EN.
module wci_initiator
  import wci_pkg::*;
#(
  parameter int unsigned TIMEOUT_LOG2 = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_space,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_code,
  input  logic        big_endian,
  output logic [2:0]  wci_MCmd,
  output logic        wci_MAddrSpace,
  output logic [3:0]  wci_MByteEn,
  output logic [31:0] wci_MAddr,
  output logic [31:0] wci_MData,
  input  logic [1:0]  wci_SResp,
  input  logic [31:0] wci_SData,
  input  logic        wci_SThreadBusy,
  input  logic [1:0]  wci_SFlag,
  output logic [1:0]  wci_MFlag,
  output logic        attention,
  output logic        present,
  output logic        stray_resp
);

  if (TIMEOUT_LOG2 < 1 || TIMEOUT_LOG2 > 31) begin : g_bad_timeout_log2
    $error("wci_initiator: TIMEOUT_LOG2 out of range");
  end

  state_e      r_state, w_state_next;
  logic        r_req_ready, w_req_ready_next;
  logic        r_write, w_write_next;
  logic [2:0]  r_mcmd, w_mcmd_next;
  logic        r_mspace, w_mspace_next;
  logic [3:0]  r_mbe, w_mbe_next;
  logic [31:0] r_maddr, w_maddr_next;
  logic [31:0] r_mdata, w_mdata_next;
  logic        r_abort, w_abort_next;
  logic        r_rsp_valid, w_rsp_valid_next;
  logic [31:0] r_rsp_data, w_rsp_data_next;
  logic [1:0]  r_rsp_code, w_rsp_code_next;
  logic        r_mflag1, r_attention, r_present, r_stray;

  logic w_accept, w_resp, w_timeout;

  assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;
  assign w_resp   = (wci_SResp != SRESP_NULL);

`ifdef WCI_INITIATOR_TIMEOUT_EN
  logic w_tc;

  wci_init_timer #(.WIDTH(TIMEOUT_LOG2)) u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_clr (w_accept),
    .i_en  ((r_state == ST_ISSUE) || (r_state == ST_WAIT)),
    .o_tc  (w_tc)
  );

  // A response arriving in the terminal cycle takes priority over the timeout.
  assign w_timeout = w_tc && ((r_state == ST_ISSUE) || ((r_state == ST_WAIT) && !w_resp));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_write_next     = r_write;
    w_mcmd_next      = r_mcmd;
    w_mspace_next    = r_mspace;
    w_mbe_next       = r_mbe;
    w_maddr_next     = r_maddr;
    w_mdata_next     = r_mdata;
    w_abort_next     = 1'b0;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_code_next  = r_rsp_code;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next  = ST_ISSUE;
          w_write_next  = req_write;
          w_mcmd_next   = req_write ? MCMD_WR : MCMD_RD;
          w_mspace_next = req_space;
          w_mbe_next    = req_be;
          w_maddr_next  = req_addr;
          w_mdata_next  = req_data;
        end
      end
      ST_ISSUE: begin
        if (w_timeout) begin
          w_state_next     = ST_RESP;
          w_mcmd_next      = MCMD_IDLE;
          w_abort_next     = 1'b1;
          w_rsp_valid_next = 1'b1;
          w_rsp_code_next  = RSP_TIMEOUT;
          w_rsp_data_next  = '0;
        end else if (!wci_SThreadBusy) begin
          w_state_next = ST_WAIT;
          w_mcmd_next  = MCMD_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_resp) begin
          w_state_next     = ST_RESP;
          w_rsp_valid_next = 1'b1;
          w_rsp_code_next  = resp_to_code(wci_SResp);
          w_rsp_data_next  = (!r_write && (wci_SResp == SRESP_DVA)) ? wci_SData : '0;
        end else if (w_timeout) begin
          w_state_next     = ST_RESP;
          w_abort_next     = 1'b1;
          w_rsp_valid_next = 1'b1;
          w_rsp_code_next  = RSP_TIMEOUT;
          w_rsp_data_next  = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next     = ST_IDLE;
          w_rsp_valid_next = 1'b0;
          w_rsp_data_next  = '0;
          w_rsp_code_next  = RSP_OK;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_req_ready_next = (w_state_next == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_write     <= 1'b0;
      r_mcmd      <= MCMD_IDLE;
      r_mspace    <= 1'b0;
      r_mbe       <= '0;
      r_maddr     <= '0;
      r_mdata     <= '0;
      r_abort     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_code  <= RSP_OK;
      r_mflag1    <= 1'b0;
      r_attention <= 1'b0;
      r_present   <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= w_req_ready_next;
      r_write     <= w_write_next;
      r_mcmd      <= w_mcmd_next;
      r_mspace    <= w_mspace_next;
      r_mbe       <= w_mbe_next;
      r_maddr     <= w_maddr_next;
      r_mdata     <= w_mdata_next;
      r_abort     <= w_abort_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rsp_code  <= w_rsp_code_next;
      r_mflag1    <= big_endian;
      r_attention <= wci_SFlag[0];
      r_present   <= wci_SFlag[1];
      r_stray     <= w_resp && (r_state != ST_WAIT);
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_code       = r_rsp_code;
  assign wci_MCmd       = r_mcmd;
  assign wci_MAddrSpace = r_mspace;
  assign wci_MByteEn    = r_mbe;
  assign wci_MAddr      = r_maddr;
  assign wci_MData      = r_mdata;
  assign wci_MFlag      = {r_mflag1, r_abort};
  assign attention      = r_attention;
  assign present        = r_present;
  assign stray_resp     = r_stray;

endmodule
